// File: rtl/nn_pkg.sv
// Shared types and helpers for the ternary network layers.
// Ternary codes, the ternary product, the bias sign-extend and the layer sizes.
package nn_pkg;

  localparam int N_L1_OUT = 48;
  localparam int N_L2_OUT = 10;

  localparam logic [1:0] TERN_POS  = 2'b01;
  localparam logic [1:0] TERN_NEG  = 2'b11;
  localparam logic [1:0] TERN_ZERO = 2'b00;

  typedef enum logic [2:0] {
    L2_IDLE,
    L2_WAIT_SRC,
    L2_BIAS,
    L2_ACCUM,
    L2_CMP,
    L2_DONE_ST
  } l2_state_e;

  // Only 01 and 11 carry a value, so bit 0 flags non-zero and
  // bit 1 is the sign; 10 decodes as zero.
  function automatic logic signed [1:0] tern_mul(
    input logic [1:0] w,
    input logic [1:0] a
  );
    if (!(w[0] & a[0])) return 2'sb00;
    return (w[1] ^ a[1]) ? 2'sb11 : 2'sb01;
  endfunction

  // Wide enough for any accumulator width; callers truncate.
  function automatic logic signed [15:0] sext_bias(
    input logic [3:0] b
  );
    return {{12{b[3]}}, b};
  endfunction

endpackage

// File: rtl/ternary_mac_acc.sv
// Signed accumulator for one ternary neuron: load bias, then add w*a per cycle.
// Ports: clk, rst_n, clr, ld/ld_val, en, w, a -> acc.
module ternary_mac_acc
  import nn_pkg::*;
#(
  parameter int ACC_W = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic                    ld,
  input  logic signed [ACC_W-1:0] ld_val,
  input  logic                    en,
  input  logic [1:0]              w,
  input  logic [1:0]              a,
  output logic signed [ACC_W-1:0] acc
);

  logic signed [1:0]       prod;
  logic signed [ACC_W-1:0] prod_ext;

  assign prod     = tern_mul(w, a);
  assign prod_ext = {{(ACC_W-2){prod[1]}}, prod};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (ld) begin
      acc <= ld_val;
    end else if (en) begin
      acc <= acc + prod_ext;
    end
  end

endmodule

// File: rtl/layer2_argmax.sv
// Layer 2: reads 48 layer-1 activations per neuron, runs 10 ternary neurons, keeps argmax.
// Ports: clk, rst_n, start, src_done, src_read_addr/src_read_data, busy, done, class_out, score_out.
module layer2_argmax
  import nn_pkg::*;
#(
  parameter int N_IN  = N_L1_OUT,
  parameter int N_OUT = N_L2_OUT,
  parameter int ACC_W = 8,
  // ROM images: weight k at bits [2k+1:2k], bias n at [4n+3:4n].
  parameter logic [N_OUT*N_IN*2-1:0] W_INIT = '0,
  parameter logic [N_OUT*4-1:0]      B_INIT = '0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    src_done,
  output logic [5:0]              src_read_addr,
  input  logic [1:0]              src_read_data,
  output logic                    busy,
  output logic                    done,
  output logic [3:0]              class_out,
  output logic signed [ACC_W-1:0] score_out
);

  localparam int W_AW = $clog2(N_OUT*N_IN);

  l2_state_e               state;
  logic [5:0]              in_idx;
  logic [3:0]              out_idx;
  logic [3:0]              best_idx;
  logic signed [ACC_W-1:0] best;
  logic signed [ACC_W-1:0] acc;

  logic [W_AW-1:0]         w_addr;
  logic [1:0]              w_cur;
  logic [3:0]              b_cur;
  logic signed [15:0]      b_ext;
  logic signed [ACC_W-1:0] b_load;
  logic                    accept;
  logic                    take;
  logic                    last_in;
  logic                    last_out;

  // in_idx is only non-zero in ACCUM, so it doubles as the address.
  assign src_read_addr = in_idx;

  assign w_addr = W_AW'(out_idx) * W_AW'(N_IN) + W_AW'(in_idx);
  assign w_cur  = W_INIT[{w_addr, 1'b0} +: 2];
  assign b_cur  = B_INIT[{out_idx, 2'b00} +: 4];
  assign b_ext  = sext_bias(b_cur);
  assign b_load = b_ext[ACC_W-1:0];

  assign accept   = (state == L2_IDLE) && start;
  assign last_in  = (in_idx == 6'(N_IN-1));
  assign last_out = (out_idx == 4'(N_OUT-1));
  // Strict compare: ties keep the earlier (lower) index.
  assign take     = (out_idx == '0) || (acc > best);

  ternary_mac_acc #(
    .ACC_W (ACC_W)
  ) u_mac (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (accept),
    .ld     (state == L2_BIAS),
    .ld_val (b_load),
    .en     (state == L2_ACCUM),
    .w      (w_cur),
    .a      (src_read_data),
    .acc    (acc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= L2_IDLE;
      in_idx    <= '0;
      out_idx   <= '0;
      best      <= '0;
      best_idx  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      class_out <= '0;
      score_out <= '0;
    end else begin
      unique case (state)
        L2_IDLE: begin
          if (start) begin
            busy    <= 1'b1;
            done    <= 1'b0;
            out_idx <= '0;
            state   <= src_done ? L2_BIAS : L2_WAIT_SRC;
          end
        end
        L2_WAIT_SRC: begin
          if (src_done) state <= L2_BIAS;
        end
        L2_BIAS: begin
          in_idx <= '0;
          state  <= L2_ACCUM;
        end
        L2_ACCUM: begin
          if (last_in) begin
            in_idx <= '0;
            state  <= L2_CMP;
          end else begin
            in_idx <= in_idx + 6'd1;
          end
        end
        L2_CMP: begin
          if (take) begin
            best     <= acc;
            best_idx <= out_idx;
          end
          if (!last_out) begin
            out_idx <= out_idx + 4'd1;
            state   <= L2_BIAS;
          end else begin
            class_out <= take ? out_idx : best_idx;
            score_out <= take ? acc : best;
            done      <= 1'b1;
            busy      <= 1'b0;
            state     <= L2_DONE_ST;
          end
        end
        L2_DONE_ST: begin
          if (!start) begin
            done  <= 1'b0;
            state <= L2_IDLE;
          end
        end
        default: state <= L2_IDLE;
      endcase
    end
  end

endmodule
